// File: rtl/mod_reduce_pkg.sv
// rtl/mod_reduce_pkg.sv - shared widths, scheduler state type and reference modulus
package mod_reduce_pkg;

  localparam int XW_DEF = 300;
  localparam int OW_DEF = 256;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } sched_state_t;

  // secp256k1 field prime; the datapath carries its own copy, this one feeds reference models
  localparam logic [OW_DEF-1:0] MODULUS =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  function automatic logic [OW_DEF-1:0] ref_reduce(input logic [XW_DEF-1:0] x);
    return OW_DEF'(x % XW_DEF'(MODULUS));
  endfunction

endpackage

// File: rtl/mod_reduce_sched_if.sv
// rtl/mod_reduce_sched_if.sv - requester, response and reduction-unit signals of the scheduler
interface mod_reduce_sched_if
  import mod_reduce_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int XW   = XW_DEF,
  parameter int OW   = OW_DEF
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*XW-1:0] req_x;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [OW-1:0]      rsp_o;
  logic               rsp_err;
  logic               red_start;
  logic [XW-1:0]      red_x;
  logic [OW-1:0]      red_o;
  logic               red_busy;

  // master is the scheduler; slave is the requester fabric plus reduction datapath
  modport master (
    input  req_valid, req_x, rsp_ready, red_o, red_busy,
    output req_ready, rsp_valid, rsp_id, rsp_o, rsp_err, red_start, red_x
  );

  modport slave (
    output req_valid, req_x, rsp_ready, red_o, red_busy,
    input  req_ready, rsp_valid, rsp_id, rsp_o, rsp_err, red_start, red_x
  );

endinterface

// File: rtl/mod_reduce_sched_rr_arbiter.sv
// rtl/mod_reduce_sched_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // ptr is always below NREQ, so one conditional subtract wraps the sum
  function automatic logic [IDW-1:0] rot(input logic [IDW-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[rot(ptr, i)]) begin
        any           = 1'b1;
        idx           = rot(ptr, i);
        gnt[rot(ptr, i)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_reduce_sched.sv
// rtl/mod_reduce_sched.sv - shares one modular reduction unit among NREQ requesters
module mod_reduce_sched
  import mod_reduce_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int XW           = XW_DEF,
  parameter int OW           = OW_DEF,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  mod_reduce_sched_if.master bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(BUSY_TIMEOUT + 1);

  sched_state_t   state;
  logic [IDW-1:0] ptr;
  logic [CW-1:0]  cnt;
  logic           start_q;
  logic [XW-1:0]  x_q;
  logic           valid_q;
  logic [IDW-1:0] id_q;
  logic [OW-1:0]  o_q;
  logic           err_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  logic [XW-1:0]   win_x;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    win_x = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IDW'(i)) win_x = bus.req_x[i*XW +: XW];
    end
  end

  // grant is only offered while idle and out of reset, so at most one operation is in flight
  assign bus.req_ready = (reset && state == IDLE) ? arb_gnt : '0;
  assign bus.red_start = start_q;
  assign bus.red_x     = x_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_o     = o_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      start_q <= 1'b0;
      x_q     <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      o_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            x_q     <= win_x;
            id_q    <= arb_idx;
            ptr     <= (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            start_q <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.red_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
            o_q     <= '0;
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.red_busy) begin
            o_q     <= bus.red_o;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
